// File: rtl/uart_io_ctrl.sv
// Processor-side UART controller: port decode, status/data read mux,
// deferred UART config, baud divisor and a single pending/ack interrupt.
module uart_io_ctrl #(
    parameter logic [3:0] RST_BAUD = 4'd4,
    parameter logic [2:0] RST_FMT  = 3'b000,
    parameter logic [1:0] RST_IEN  = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] port_id,
    input  logic [7:0]  out_port,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic        int_ack,
    input  logic        txrdy,
    input  logic        rxrdy,
    input  logic        ferr,
    input  logic        perr,
    input  logic        ovf,
    input  logic [7:0]  rx_data,
    output logic [7:0]  in_port,
    output logic        interrupt,
    output logic        tx_load,
    output logic [7:0]  tx_data,
    output logic        rx_clr,
    output logic [18:0] k,
    output logic        eight,
    output logic        pen,
    output logic        ohel
);

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_ASSERT,
        IRQ_WAIT
    } irq_state_e;

    function automatic logic [18:0] baud_k(input logic [3:0] code);
        logic [18:0] r;
        case (code)
            4'd0:    r = 19'd333333;
            4'd1:    r = 19'd83333;
            4'd2:    r = 19'd41667;
            4'd3:    r = 19'd20833;
            4'd4:    r = 19'd10417;
            4'd5:    r = 19'd5208;
            4'd6:    r = 19'd2604;
            4'd7:    r = 19'd1736;
            4'd8:    r = 19'd868;
            4'd9:    r = 19'd434;
            4'd10:   r = 19'd217;
            4'd11:   r = 19'd109;
            default: r = 19'd10417;
        endcase
        return r;
    endfunction

    logic       wr_tx, wr_cfg, wr_ien;
    logic       rd_rx, rd_st;
    logic       tx_edge, rx_edge, ack_take;
    logic [7:0] status;

    logic        tx_load_q, tx_load_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_clr_q, rx_clr_d;
    logic [2:0]  sticky_q, sticky_d;
    logic [6:0]  shadow_q, shadow_d;
    logic [6:0]  active_q, active_d;
    logic        cfg_pend_q, cfg_pend_d;
    logic [1:0]  ien_q, ien_d;
    logic [18:0] k_q, k_d;
    logic        txrdy_q, txrdy_d;
    logic        rxrdy_q, rxrdy_d;
    logic        tx_pend_q, tx_pend_d;
    logic        rx_pend_q, rx_pend_d;
    irq_state_e  state_q, state_d;

    always_comb begin
        wr_tx  = write_strobe && (port_id == 16'd0);
        wr_cfg = write_strobe && (port_id == 16'd2);
        wr_ien = write_strobe && (port_id == 16'd3);
        rd_rx  = read_strobe && (port_id == 16'd0);
        rd_st  = read_strobe && (port_id == 16'd1);
    end

    assign status = {rx_pend_q, tx_pend_q, cfg_pend_q,
                     sticky_q, rxrdy, txrdy};

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            16'd0:   in_port = rx_data;
            16'd1:   in_port = status;
            16'd2:   in_port = {1'b0, shadow_q};
            16'd3:   in_port = {6'b0, ien_q};
            default: in_port = 8'h00;
        endcase
    end

    always_comb begin
        tx_load_d = wr_tx;
        tx_data_d = wr_tx ? out_port : tx_data_q;
        rx_clr_d  = rd_rx;
        // A fresh error in the clearing cycle must survive the clear
        sticky_d  = (rd_st ? 3'b000 : sticky_q) | {ovf, perr, ferr};
        ien_d     = wr_ien ? out_port[1:0] : ien_q;

        active_d   = active_q;
        shadow_d   = shadow_q;
        cfg_pend_d = cfg_pend_q;
        if (cfg_pend_q && txrdy && !tx_load_q) begin
            active_d   = shadow_q;
            cfg_pend_d = 1'b0;
        end
        if (wr_cfg) begin
            shadow_d   = out_port[6:0];
            cfg_pend_d = 1'b1;
        end
        k_d = baud_k(active_d[6:3]);
    end

    always_comb begin
        txrdy_d   = txrdy;
        rxrdy_d   = rxrdy;
        tx_edge   = txrdy && !txrdy_q && ien_q[0];
        rx_edge   = rxrdy && !rxrdy_q && ien_q[1];
        ack_take  = (state_q == IRQ_ASSERT) && int_ack;
        tx_pend_d = (tx_pend_q && !ack_take) || tx_edge;
        rx_pend_d = (rx_pend_q && !ack_take) || rx_edge;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: begin
                if (tx_pend_q || rx_pend_q) state_d = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                if (int_ack) state_d = IRQ_WAIT;
            end
            IRQ_WAIT: state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_load_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_clr_q   <= 1'b0;
            sticky_q   <= 3'b000;
            shadow_q   <= {RST_BAUD, RST_FMT};
            active_q   <= {RST_BAUD, RST_FMT};
            cfg_pend_q <= 1'b0;
            ien_q      <= RST_IEN;
            k_q        <= baud_k(RST_BAUD);
            txrdy_q    <= 1'b0;
            rxrdy_q    <= 1'b0;
            tx_pend_q  <= 1'b0;
            rx_pend_q  <= 1'b0;
            state_q    <= IRQ_IDLE;
        end else begin
            tx_load_q  <= tx_load_d;
            tx_data_q  <= tx_data_d;
            rx_clr_q   <= rx_clr_d;
            sticky_q   <= sticky_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            cfg_pend_q <= cfg_pend_d;
            ien_q      <= ien_d;
            k_q        <= k_d;
            txrdy_q    <= txrdy_d;
            rxrdy_q    <= rxrdy_d;
            tx_pend_q  <= tx_pend_d;
            rx_pend_q  <= rx_pend_d;
            state_q    <= state_d;
        end
    end

    assign tx_load   = tx_load_q;
    assign tx_data   = tx_data_q;
    assign rx_clr    = rx_clr_q;
    assign k         = k_q;
    assign eight     = active_q[0];
    assign pen       = active_q[1];
    assign ohel      = active_q[2];
    assign interrupt = (state_q == IRQ_ASSERT);

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Bench for uart_io_ctrl: directed scenarios plus random traffic,
// all cycles compared against a behavioural model of the port map.
module tb_uart_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] port_id;
    logic [7:0]  out_port;
    logic        write_strobe, read_strobe, int_ack;
    logic        txrdy, rxrdy, ferr, perr, ovf;
    logic [7:0]  rx_data;
    logic [7:0]  in_port;
    logic        interrupt, tx_load, rx_clr;
    logic [7:0]  tx_data;
    logic [18:0] k;
    logic        eight, pen, ohel;

    int n_tests = 0;
    int n_fail  = 0;

    int baud_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208,
                          2604, 1736, 868, 434, 217, 109,
                          10417, 10417, 10417, 10417};

    uart_io_ctrl dut (
        .clk(clk), .reset(reset), .port_id(port_id),
        .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .int_ack(int_ack),
        .txrdy(txrdy), .rxrdy(rxrdy), .ferr(ferr), .perr(perr),
        .ovf(ovf), .rx_data(rx_data), .in_port(in_port),
        .interrupt(interrupt), .tx_load(tx_load), .tx_data(tx_data),
        .rx_clr(rx_clr), .k(k), .eight(eight), .pen(pen), .ohel(ohel)
    );

    always #5 clk = ~clk;

    // model state, expressed as what software would observe
    logic       m_tx_load, m_rx_clr, m_irq, m_hold;
    logic [7:0] m_tx_data;
    logic [2:0] m_sticky;
    logic [6:0] m_shadow, m_active;
    logic       m_cfg_pend, m_txp, m_rxp, m_prev_tx, m_prev_rx;
    logic [1:0] m_ien;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tx_load = 0; m_rx_clr = 0; m_irq = 0; m_hold = 0;
        m_tx_data = 0; m_sticky = 0;
        m_shadow = {4'd4, 3'b000}; m_active = {4'd4, 3'b000};
        m_cfg_pend = 0; m_txp = 0; m_rxp = 0;
        m_prev_tx = 0; m_prev_rx = 0; m_ien = 2'b00;
    endtask

    task automatic model_step();
        logic wt, rr, rs1, w2, w3, ack_ok, txe, rxe;
        wt  = write_strobe && port_id == 16'd0;
        w2  = write_strobe && port_id == 16'd2;
        w3  = write_strobe && port_id == 16'd3;
        rr  = read_strobe && port_id == 16'd0;
        rs1 = read_strobe && port_id == 16'd1;
        ack_ok = m_irq && int_ack;
        txe = txrdy && !m_prev_tx && m_ien[0];
        rxe = rxrdy && !m_prev_rx && m_ien[1];
        if (m_irq) begin
            m_irq  = !int_ack;
            m_hold = int_ack;
        end else if (m_hold) begin
            m_hold = 0;
        end else begin
            m_irq = m_txp || m_rxp;
        end
        m_txp = (ack_ok ? 1'b0 : m_txp) | txe;
        m_rxp = (ack_ok ? 1'b0 : m_rxp) | rxe;
        m_prev_tx = txrdy;
        m_prev_rx = rxrdy;
        if (m_cfg_pend && txrdy && !m_tx_load) begin
            m_active   = m_shadow;
            m_cfg_pend = 0;
        end
        if (w2) begin
            m_shadow   = out_port[6:0];
            m_cfg_pend = 1;
        end
        if (w3) m_ien = out_port[1:0];
        m_sticky = (rs1 ? 3'b000 : m_sticky) | {ovf, perr, ferr};
        m_tx_load = wt;
        if (wt) m_tx_data = out_port;
        m_rx_clr = rr;
    endtask

    function automatic logic [7:0] exp_in_port();
        case (port_id)
            16'd0:   return rx_data;
            16'd1:   return {m_rxp, m_txp, m_cfg_pend, m_sticky,
                             rxrdy, txrdy};
            16'd2:   return {1'b0, m_shadow};
            16'd3:   return {6'b0, m_ien};
            default: return 8'h00;
        endcase
    endfunction

    // compare mid-cycle, then advance the model on the edge
    task automatic cycle();
        @(negedge clk);
        chk("in_port", in_port, exp_in_port());
        chk("tx_load", tx_load, m_tx_load);
        chk("tx_data", tx_data, m_tx_data);
        chk("rx_clr", rx_clr, m_rx_clr);
        chk("irq", interrupt, m_irq);
        chk("k", k, baud_tab[m_active[6:3]]);
        chk("fmt", {ohel, pen, eight}, m_active[2:0]);
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    initial begin
        logic got;
        int r;
        reset = 0; port_id = 0; out_port = 0;
        write_strobe = 0; read_strobe = 0; int_ack = 0;
        txrdy = 0; rxrdy = 0; ferr = 0; perr = 0; ovf = 0; rx_data = 0;
        model_reset();
        repeat (3) cycle();
        reset = 1;
        repeat (2) cycle();

        // reset dropped during a tx write
        port_id = 0; out_port = 8'hA5; write_strobe = 1;
        #2 reset = 0;
        model_reset();
        cycle();
        write_strobe = 0;
        chk("rst_w0", tx_load, 1'b0);
        cycle();
        reset = 1;
        repeat (3) begin
            cycle();
            chk("rst_noload", tx_load, 1'b0);
        end
        chk("rst_k", k, 19'd10417);
        chk("rst_fmt", {ohel, pen, eight}, 3'b000);
        chk("rst_irq", interrupt, 1'b0);

        // tx write; txrdy edge with tx_ien=0 must not interrupt
        txrdy = 1; port_id = 0; out_port = 8'h5A; write_strobe = 1;
        cycle();
        write_strobe = 0;
        chk("w0_load", tx_load, 1'b1);
        chk("w0_data", tx_data, 8'h5A);
        cycle();
        chk("w0_once", tx_load, 1'b0);
        chk("tx_noirq", interrupt, 1'b0);

        // rx read
        rx_data = 8'hC3; read_strobe = 1;
        #1 chk("r0_data", in_port, 8'hC3);
        cycle();
        read_strobe = 0;
        chk("r0_clr", rx_clr, 1'b1);
        cycle();
        chk("r0_clr_once", rx_clr, 1'b0);

        // deferred config
        txrdy = 0; port_id = 2; out_port = 8'h48; write_strobe = 1;
        cycle();
        write_strobe = 0;
        repeat (3) cycle();
        chk("cfg_hold_k", k, 19'd10417);
        port_id = 1;
        #1 chk("cfg_pend", in_port[5], 1'b1);
        txrdy = 1;
        cycle();
        chk("cfg_k", k, 19'd434);
        chk("cfg_pend_clr", in_port[5], 1'b0);

        // rx interrupt and ack
        port_id = 3; out_port = 8'h02; write_strobe = 1;
        cycle();
        write_strobe = 0; rxrdy = 1;
        cycle();
        cycle();
        chk("irq_set", interrupt, 1'b1);
        int_ack = 1;
        cycle();
        int_ack = 0;
        chk("irq_ack", interrupt, 1'b0);
        cycle();
        chk("irq_gap", interrupt, 1'b0);
        txrdy = 0;
        cycle();
        txrdy = 1;
        repeat (3) cycle();
        chk("tx_ien0", interrupt, 1'b0);

        // rxrdy edge coincident with the ack
        rxrdy = 0;
        cycle();
        rxrdy = 1;
        cycle();
        cycle();
        chk("irq2_set", interrupt, 1'b1);
        rxrdy = 0;
        cycle();
        rxrdy = 1; int_ack = 1;
        cycle();
        int_ack = 0;
        chk("irq2_drop", interrupt, 1'b0);
        got = 0;
        repeat (3) begin
            cycle();
            if (interrupt) got = 1;
        end
        chk("irq2_reraise", got, 1'b1);
        int_ack = 1;
        cycle();
        int_ack = 0;

        // sticky ferr and read-clear
        port_id = 1; ferr = 1;
        cycle();
        ferr = 0;
        chk("st_ferr", in_port[2], 1'b1);
        read_strobe = 1;
        cycle();
        read_strobe = 0;
        chk("st_clr", in_port[2], 1'b0);
        ferr = 1;
        cycle();
        read_strobe = 1;
        cycle();
        read_strobe = 0; ferr = 0;
        chk("st_win", in_port[2], 1'b1);
        cycle();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            port_id = (r <= 4) ? 16'(r) : 16'($urandom());
            out_port = 8'($urandom());
            rx_data = 8'($urandom());
            write_strobe = ($urandom_range(0, 3) == 0);
            read_strobe = ($urandom_range(0, 3) == 0);
            int_ack = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) txrdy = ~txrdy;
            if ($urandom_range(0, 3) == 0) rxrdy = ~rxrdy;
            ferr = ($urandom_range(0, 7) == 0);
            perr = ($urandom_range(0, 7) == 0);
            ovf = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
